// File: rtl/t06_pulse_stretcher.sv
// Retriggerable pulse stretcher: a trig starts a len-cycle high pulse followed by
// an optional holdoff dead time. All outputs come from registered state only.
module t06_pulse_stretcher #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] holdoff,
  input  logic             retrig,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             dropped
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] ho_lat, ho_nxt;
  logic             done_q, done_nxt;
  logic             dropped_q, dropped_nxt;
  logic             len_ok, cnt_last;

  assign len_ok   = (len != '0);
  assign cnt_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      ho_lat    <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ho_lat    <= ho_nxt;
      done_q    <= done_nxt;
      dropped_q <= dropped_nxt;
    end
  end

  // cnt holds the remaining cycles of the current phase; it is never 0 outside IDLE,
  // so the cnt_last test is what ends each phase and the counter cannot wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ho_nxt      = ho_lat;
    done_nxt    = 1'b0;
    dropped_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (len_ok) begin
            state_nxt = ACTIVE;
            cnt_nxt   = len;
            ho_nxt    = holdoff;
          end else begin
            dropped_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A reload takes priority over the end of pulse, so a retrig in the last
        // high cycle extends without a gap and suppresses the superseded done.
        if (trig && retrig && len_ok) begin
          cnt_nxt = len;
          ho_nxt  = holdoff;
        end else begin
          dropped_nxt = trig;
          if (cnt_last) begin
            done_nxt = 1'b1;
            if (ho_lat != '0) begin
              state_nxt = HOLDOFF;
              cnt_nxt   = ho_lat;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      HOLDOFF: begin
        dropped_nxt = trig;
        if (cnt_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_out = (state == ACTIVE);
    busy      = (state != IDLE);
    done      = done_q;
    dropped   = dropped_q;
  end

endmodule

// File: tb/tb_t06_pulse_stretcher.sv
// Directed and random stimulus against a timeline model: each accepted trig
// fixes the absolute cycle numbers at which the pulse and the holdoff end.
module tb_t06_pulse_stretcher;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       trig = 1'b0;
  logic [7:0] len = '0;
  logic [7:0] holdoff = '0;
  logic       retrig = 1'b0;
  logic       pulse_out, busy, done, dropped;

  int n_chk = 0;
  int n_err = 0;

  // Model: cycle c is the period ending at the c-th sampled rising edge.
  int cyc     = 0;
  int end_act = -2;  // last cycle with pulse_out high
  int end_ho  = -2;  // last cycle with busy high
  int drop_at = -2;  // cycle in which dropped is expected

  t06_pulse_stretcher #(.CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .trig(trig), .len(len), .holdoff(holdoff),
    .retrig(retrig), .pulse_out(pulse_out), .busy(busy), .done(done),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pulse_out", pulse_out, cyc <= end_act);
    chk("busy",      busy,      cyc <= end_ho);
    chk("done",      done,      cyc == end_act + 1);
    chk("dropped",   dropped,   cyc == drop_at);
  endtask

  // One cycle: check the current outputs, drive this cycle's inputs, then advance
  // the timeline for the edge that will sample them.
  task automatic step(input bit t, input logic [7:0] l, input logic [7:0] h, input bit r);
    bit active, idle, accept;
    @(negedge clk);
    check_outputs();
    nrst = 1'b1;
    trig = t; len = l; holdoff = h; retrig = r;
    active = (cyc <= end_act);
    idle   = (cyc > end_ho);
    accept = t && (l != 0) && (idle || (active && r));
    if (accept) begin
      end_act = cyc + int'(l);
      end_ho  = end_act + int'(h);
    end else if (t) begin
      drop_at = cyc + 1;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // Asserts reset mid-cycle and holds it for 1+hold edges; the next step releases it.
  task automatic apply_reset(input int hold);
    @(negedge clk);
    check_outputs();
    nrst = 1'b0;
    trig = 1'b0;
    #1;
    chk("rst_pulse_out", pulse_out, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_dropped",   dropped,   1'b0);
    end_act = -2; end_ho = -2; drop_at = -2;
    cyc++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_outputs();
      cyc++;
    end
  endtask

  initial begin
    apply_reset(2);
    // basic pulse, no holdoff
    step(1, 8'd4, 8'd0, 0); idle_steps(6);
    // holdoff with a trig landing in the first dead cycle
    step(1, 8'd3, 8'd2, 0); idle_steps(3);
    step(1, 8'd3, 8'd2, 0); idle_steps(4);
    // retrig extends
    step(1, 8'd4, 8'd0, 1); idle_steps(2);
    step(1, 8'd4, 8'd0, 1); idle_steps(6);
    // retrig disabled drops
    step(1, 8'd4, 8'd0, 0); idle_steps(1);
    step(1, 8'd4, 8'd0, 0); idle_steps(5);
    // zero length
    step(1, 8'd0, 8'd0, 0); idle_steps(3);
    // retrig in the last high cycle
    step(1, 8'd3, 8'd1, 1); idle_steps(2);
    step(1, 8'd3, 8'd1, 1); idle_steps(6);
    // trig in the done cycle
    step(1, 8'd2, 8'd0, 0); idle_steps(2);
    step(1, 8'd2, 8'd0, 0); idle_steps(4);
    // reset mid-pulse, trig at the first edge after release
    step(1, 8'd10, 8'd0, 0); idle_steps(4);
    apply_reset(0);
    step(1, 8'd3, 8'd0, 0); idle_steps(5);
    // reset mid-holdoff
    step(1, 8'd2, 8'd5, 0); idle_steps(4);
    apply_reset(1);
    idle_steps(2);
    // maximum length and holdoff
    step(1, 8'd255, 8'd255, 0); idle_steps(515);
    // random traffic, inputs wander between trigs
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(0, 2));
      end else begin
        step($urandom_range(0, 99) < 35,
             ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6)),
             8'($urandom_range(0, 3)), 1'($urandom));
      end
    end
    idle_steps(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
